imem_loader: RTL and testbench

- Program loader: the write side of the instruction memory that the processor fetches from.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into consecutive instruction-memory word addresses starting at 0, then verifies an XOR checksum.
- Holds the processor in reset (cpu_hold) for the whole load, so execution restarts from PC 0 with the new program.

---
 rtl/imem_pkg.sv | 17 +
 rtl/byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int IMEM_DEPTH  = 16;
  localparam int IMEM_ADDR_W = 4;
  localparam int WORD_W      = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte to 32-bit word assembler; word_ready pulses the cycle after the 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              ready_q, ready_d;

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (push) begin
      // Shift left so the first byte of a word ends up in the top lane.
      word_d  = {word_q[WORD_W-9:0], byte_in};
      idx_d   = idx_q + 2'd1;
      ready_d = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  assign word       = word_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: length byte, N big-endian words, XOR checksum byte.
// Keeps the processor held in reset while loading and after a failed load.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [8:0]      DEPTH_LIM = 9'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              restart;
  logic              pk_push;
  logic              pk_ready;
  logic [WORD_W-1:0] pk_word;

  assign restart = start && (state_q inside {IDLE, DONE, ERROR});
  assign pk_push = (state_q == DATA) && in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .push       (pk_push),
    .byte_in    (in_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    in_ready   = 1'b0;

    if (restart) begin
      state_d    = LEN;
      len_d      = '0;
      word_cnt_d = '0;
      csum_d     = '0;
      addr_d     = '0;
    end else begin
      case (state_q)
        LEN: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_LIM) begin
              state_d = ERROR;
            end else begin
              len_d   = in_data[ADDR_W:0];
              state_d = DATA;
            end
          end
        end
        DATA: begin
          // The write cycle is a bubble so the source can never outrun the packer.
          in_ready = !pk_ready;
          if (pk_push) begin
            csum_d = csum_q ^ in_data;
            addr_d = word_cnt_q[ADDR_W-1:0];
          end
          if (pk_ready) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
            if (word_cnt_q + CNT_ONE == len_q) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = (in_data == csum_q) ? DONE : ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
    end
  end

  assign wr_en     = pk_ready;
  assign wr_addr   = addr_q;
  assign wr_data   = pk_word;
  assign cpu_hold  = state_q inside {LEN, DATA, CHECK, ERROR};
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for a nominal load, then stream-level loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  logic [3:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_words[$];

  typedef struct {
    logic        start;
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write-port monitor: records every write and requires in_ready low on write cycles.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      check("ready_low_on_write", 32'(in_ready), 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("byte %h accepted", b);
  endtask

  function automatic logic [7:0] csum_of();
    logic [7:0] c;
    c = 8'h00;
    foreach (exp_words[w]) c ^= exp_words[w][31:24] ^ exp_words[w][23:16] ^ exp_words[w][15:8] ^ exp_words[w][7:0];
    return c;
  endfunction

  task automatic do_load(input bit with_start, input logic [7:0] n, input logic [7:0] cs,
                         input int max_gap, input bit poke, input bit exp_ok);
    logic [31:0] wv;
    int exp_cnt;
    got_addr.delete();
    got_data.delete();
    if (with_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_byte(n, 0);
    exp_cnt = 0;
    if (n != 8'd0 && n <= 8'd16) begin
      exp_cnt = exp_words.size();
      foreach (exp_words[w]) begin
        wv = exp_words[w];
        for (int b = 0; b < 4; b++) begin
          send_byte(wv[31-8*b -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
          if (poke && w == 0 && b == 1) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
          end
        end
      end
      send_byte(cs, 0);
    end
    $display("load n=%0d cs=%h: done=%b err=%b hold=%b writes=%0d",
             n, cs, load_done, load_err, cpu_hold, got_addr.size());
    check("load_done", 32'(load_done), 32'(exp_ok));
    check("load_err", 32'(load_err), 32'(!exp_ok));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
    check("ready_after_load", 32'(in_ready), 32'd0);
    check("write_count", 32'(got_addr.size()), 32'(exp_cnt));
    for (int i = 0; i < exp_cnt && i < got_addr.size(); i++) begin
      check("write_addr", 32'(got_addr[i]), 32'(i));
      check("write_data", got_data[i], exp_words[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 4'h0, 32'hA0210000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h62, 1'b0, 1'b1, 4'h1, 32'hA0420001, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h62, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Cycle-exact nominal load; row 0 doubles as the reset-state check.
    for (int i = 0; i < 14; i++) begin
      start    = vecs[i].start;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].din;
      $display("cycle %0d: rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b",
               i, in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err);
      check("tbl_in_ready", 32'(in_ready), 32'(vecs[i].rdy));
      check("tbl_wr_en", 32'(wr_en), 32'(vecs[i].wen));
      check("tbl_cpu_hold", 32'(cpu_hold), 32'(vecs[i].hold));
      check("tbl_load_done", 32'(load_done), 32'(vecs[i].done));
      check("tbl_load_err", 32'(load_err), 32'(vecs[i].err));
      if (vecs[i].wen || i == 0) begin
        check("tbl_wr_addr", 32'(wr_addr), 32'(vecs[i].addr));
        check("tbl_wr_data", wr_data, vecs[i].wdata);
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // Bad checksum: both words land, load fails, processor stays held.
    exp_words = '{32'hA0210000, 32'hA0420001};
    do_load(1'b1, 8'h02, 8'h63, 0, 1'b0, 1'b0);

    // start from ERROR clears load_err and re-enters LEN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("restart from error: err=%b rdy=%b hold=%b", load_err, in_ready, cpu_hold);
    check("err_restart_load_err", 32'(load_err), 32'd0);
    check("err_restart_in_ready", 32'(in_ready), 32'd1);
    check("err_restart_cpu_hold", 32'(cpu_hold), 32'd1);
    do_load(1'b0, 8'h02, 8'h62, 0, 1'b0, 1'b1);

    // Length limits.
    do_load(1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    do_load(1'b1, 8'h11, 8'h00, 0, 1'b0, 1'b0);
    exp_words.delete();
    for (int i = 0; i < 16; i++) exp_words.push_back({i[7:0], 8'hC3, 8'(i * 37 + 1), 8'h5A});
    do_load(1'b1, 8'h10, csum_of(), 0, 1'b0, 1'b1);

    // Input gaps around write bubbles.
    exp_words = '{32'h12345678, 32'hDEADBEEF, 32'h00FF00FF};
    do_load(1'b1, 8'h03, csum_of(), 3, 1'b0, 1'b1);

    // start pulsed mid-DATA must be ignored.
    exp_words = '{32'hA0210000, 32'hA0420001};
    do_load(1'b1, 8'h02, 8'h62, 0, 1'b1, 1'b1);

    // Reset after 6 data bytes abandons the load.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h21, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h42, 0);
    reset = 1'b1;
    @(negedge clk);
    $display("mid-load reset: rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b",
             in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    do_load(1'b1, 8'h02, 8'h62, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
